// File: rtl/mio_port_arbiter_pkg.sv
// Shared encodings and sizing helpers for the MIO port arbiter.
package mio_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned TW = $clog2(TIMEOUT_DEF);

  // Width able to hold TIMEOUT-1 for any legal TIMEOUT.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mio_wait_timer.sv
// Wait-state counter: clears, counts while enabled, saturates at TIMEOUT-1 and flags it.
module mio_wait_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [W-1:0] Last = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != Last)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == Last);

endmodule

// File: rtl/mio_port_arbiter.sv
// Two-master (CPU / debug) arbiter for the single MIO port with ready handshake and timeout.
module mio_port_arbiter
  import mio_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_wea,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [3:0]  dbg_wea,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_done,
  output logic        dbg_err,
  output logic        mem_req,
  output logic        mem_w,
  output logic [3:0]  mem_wea,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        grant_dbg
);

  localparam int unsigned TmrW = timer_width(TIMEOUT);

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic        we_q;
  logic [3:0]  wea_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] cpu_rdata_q, dbg_rdata_q;
  logic        cpu_done_q, dbg_done_q, err_q;

  logic cpu_elig, dbg_elig, any_elig, pick_dbg;
  logic xfer, tc, xfer_end, timed_out;

  mio_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .W       (TmrW)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == ST_IDLE),
    .enable (xfer && !mem_ready),
    .tc     (tc)
  );

  // A requester in its done cycle is not eligible, so it cannot be re-served by a stale req.
  assign cpu_elig  = cpu_req && !cpu_done_q;
  assign dbg_elig  = dbg_req && !dbg_done_q;
  assign any_elig  = cpu_elig || dbg_elig;
  assign pick_dbg  = dbg_elig && (!cpu_elig || (last_grant_q == GNT_CPU));
  assign xfer      = (state_q == ST_XFER);
  assign xfer_end  = xfer && (mem_ready || tc);
  assign timed_out = xfer && !mem_ready && tc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_elig) state_d = ST_XFER;
      ST_XFER: if (mem_ready || tc) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= GNT_CPU;
      we_q         <= 1'b0;
      wea_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      dbg_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      dbg_done_q <= 1'b0;
      err_q      <= 1'b0;
      if ((state_q == ST_IDLE) && any_elig) begin
        last_grant_q <= pick_dbg;
        we_q         <= pick_dbg ? dbg_we    : cpu_we;
        wea_q        <= pick_dbg ? dbg_wea   : cpu_wea;
        addr_q       <= pick_dbg ? dbg_addr  : cpu_addr;
        wdata_q      <= pick_dbg ? dbg_wdata : cpu_wdata;
      end
      if (xfer_end) begin
        err_q <= timed_out;
        if (last_grant_q == GNT_DBG) begin
          dbg_done_q <= 1'b1;
          if (timed_out)  dbg_rdata_q <= ERR_RDATA;
          else if (!we_q) dbg_rdata_q <= mem_rdata;
        end else begin
          cpu_done_q <= 1'b1;
          if (timed_out)  cpu_rdata_q <= ERR_RDATA;
          else if (!we_q) cpu_rdata_q <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    mem_req   = xfer;
    mem_w     = xfer && we_q;
    mem_wea   = (xfer && we_q) ? wea_q : 4'b0000;
    mem_addr  = xfer ? addr_q : 32'h0;
    mem_wdata = xfer ? wdata_q : 32'h0;
    cpu_rdata = cpu_rdata_q;
    dbg_rdata = dbg_rdata_q;
    cpu_done  = cpu_done_q;
    dbg_done  = dbg_done_q;
    cpu_err   = cpu_done_q && err_q;
    dbg_err   = dbg_done_q && err_q;
    cpu_stall = cpu_req && !cpu_done_q;
    grant_dbg = last_grant_q;
  end

endmodule

// File: tb/tb_mio_port_arbiter.sv
// Directed bench for mio_port_arbiter: completion scoreboard plus cycle-level port checks.
module tb_mio_port_arbiter;

  typedef struct packed {
    logic        dbg;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, cpu_done, cpu_err, cpu_stall;
  logic [3:0]  cpu_wea;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_done, dbg_err;
  logic [3:0]  dbg_wea;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_req, mem_w, mem_ready, grant_dbg;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  mio_port_arbiter #(
    .TIMEOUT   (4),
    .ERR_RDATA (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_wea   (cpu_wea),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_wea   (dbg_wea),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_done  (dbg_done),
    .dbg_err   (dbg_err),
    .mem_req   (mem_req),
    .mem_w     (mem_w),
    .mem_wea   (mem_wea),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .grant_dbg (grant_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic d, input logic er, input logic [31:0] rd);
    exp_t e;
    e.dbg   = d;
    e.err   = er;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && (cpu_done || dbg_done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {30'b0, dbg_done, cpu_done}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_src", {30'b0, dbg_done, cpu_done}, mon_e.dbg ? 32'h2 : 32'h1);
        chk("done_err", {31'b0, mon_e.dbg ? dbg_err : cpu_err}, {31'b0, mon_e.err});
        chk("done_rdata", mon_e.dbg ? dbg_rdata : cpu_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_wea = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_wea = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_done", {30'b0, dbg_done, cpu_done}, 0);
    chk("rst_grant", {31'b0, grant_dbg}, 0);
    chk("rst_rdata", cpu_rdata | dbg_rdata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // CPU read, ready in first XFER cycle
    tick(); cpu_req = 1; cpu_addr = 32'h100; push(0, 0, 32'hCAFE_F00D);
    #2 chk("t1_c0_stall", {31'b0, cpu_stall}, 1); chk("t1_c0_mem_req", {31'b0, mem_req}, 0);
    tick(); mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
    #2 chk("t1_c1_mem_req", {31'b0, mem_req}, 1); chk("t1_c1_addr", mem_addr, 32'h100);
    chk("t1_c1_mem_w", {31'b0, mem_w}, 0); chk("t1_c1_stall", {31'b0, cpu_stall}, 1);
    tick(); mem_ready = 0;
    #2 chk("t1_c2_done", {31'b0, cpu_done}, 1); chk("t1_c2_stall", {31'b0, cpu_stall}, 0);
    cpu_req = 0;

    // Contention, last_grant=CPU so debug first
    tick(); cpu_req = 1; cpu_addr = 32'h200; dbg_req = 1; dbg_addr = 32'h300;
    push(1, 0, 32'h1111_2222); push(0, 0, 32'h3333_4444);
    #2 chk("t2_c0_mem_req", {31'b0, mem_req}, 0);
    tick(); mem_ready = 1; mem_rdata = 32'h1111_2222;
    #2 chk("t2_c1_grant", {31'b0, grant_dbg}, 1); chk("t2_c1_addr", mem_addr, 32'h300);
    chk("t2_c1_stall", {31'b0, cpu_stall}, 1);
    tick(); mem_ready = 0;
    #2 chk("t2_c2_dbg_done", {31'b0, dbg_done}, 1); chk("t2_c2_grant", {31'b0, grant_dbg}, 1);
    dbg_req = 0;
    tick(); mem_ready = 1; mem_rdata = 32'h3333_4444;
    #2 chk("t2_c3_grant", {31'b0, grant_dbg}, 0); chk("t2_c3_addr", mem_addr, 32'h200);
    tick(); mem_ready = 0;
    #2 chk("t2_c4_cpu_done", {31'b0, cpu_done}, 1); chk("t2_c4_grant", {31'b0, grant_dbg}, 0);
    cpu_req = 0;

    // Debug write, 3 wait states; ready coincides with the last timer count
    tick(); dbg_req = 1; dbg_we = 1; dbg_wea = 4'b0011; dbg_addr = 32'h20; dbg_wdata = 32'h1234;
    mem_rdata = 32'hDEAD_BEEF; push(1, 0, 32'h1111_2222);
    for (int i = 1; i <= 4; i++) begin
      tick(); if (i == 4) mem_ready = 1;
      #2 chk("t3_mem_w", {31'b0, mem_w}, 1); chk("t3_mem_wea", {28'b0, mem_wea}, 32'h3);
      chk("t3_addr", mem_addr, 32'h20); chk("t3_wdata", mem_wdata, 32'h1234);
      chk("t3_no_done", {31'b0, dbg_done}, 0);
    end
    tick(); mem_ready = 0;
    #2 chk("t3_c5_done", {31'b0, dbg_done}, 1); chk("t3_c5_err", {31'b0, dbg_err}, 0);
    chk("t3_c5_mem_req", {31'b0, mem_req}, 0);
    dbg_req = 0; dbg_we = 0; dbg_wea = 0;

    // Timeout with TIMEOUT=4, then follow-up access
    tick(); cpu_req = 1; cpu_addr = 32'h400; mem_rdata = 32'h9999_9999; push(0, 1, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      #2 chk("t4_mem_req", {31'b0, mem_req}, 1); chk("t4_no_done", {31'b0, cpu_done}, 0);
    end
    tick();
    #2 chk("t4_c5_done", {31'b0, cpu_done}, 1); chk("t4_c5_err", {31'b0, cpu_err}, 1);
    chk("t4_c5_rdata", cpu_rdata, 32'h0); chk("t4_c5_mem_req", {31'b0, mem_req}, 0);
    cpu_addr = 32'h404; push(0, 0, 32'h5555_AAAA);
    tick();
    #2 chk("t4_c6_mem_req", {31'b0, mem_req}, 0);
    tick(); mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    #2 chk("t4_c7_addr", mem_addr, 32'h404);
    tick(); mem_ready = 0;
    #2 chk("t4_c8_done", {31'b0, cpu_done}, 1); chk("t4_c8_err", {31'b0, cpu_err}, 0);
    cpu_req = 0;

    // mem_ready in IDLE is ignored
    tick(); mem_ready = 1;
    #2 chk("idle_rdy_mem_req", {31'b0, mem_req}, 0);
    tick(); mem_ready = 0;
    #2 chk("idle_rdy_no_done", {30'b0, dbg_done, cpu_done}, 0);
    tick();
    #2 chk("idle_rdy_no_done2", {30'b0, dbg_done, cpu_done}, 0);

    // Asynchronous reset mid-transfer
    tick(); dbg_req = 1; dbg_addr = 32'h600;
    tick();
    #2 chk("t5_c1_mem_req", {31'b0, mem_req}, 1);
    tick();
    #2 rst_n = 0;
    #1 chk("t5_rst_mem_req", {31'b0, mem_req}, 0); chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_grant", {31'b0, grant_dbg}, 0); chk("t5_rst_rdata", cpu_rdata | dbg_rdata, 0);
    dbg_req = 0;
    tick(); tick(); rst_n = 1;
    tick(); cpu_req = 1; cpu_addr = 32'h700; dbg_req = 1; dbg_addr = 32'h800;
    push(1, 0, 32'hAAAA_0001); push(0, 0, 32'hBBBB_0002);
    tick(); mem_ready = 1; mem_rdata = 32'hAAAA_0001;
    #2 chk("t5_grant_dbg", {31'b0, grant_dbg}, 1); chk("t5_addr_dbg", mem_addr, 32'h800);
    tick(); mem_ready = 0; dbg_req = 0;
    tick(); mem_ready = 1; mem_rdata = 32'hBBBB_0002;
    #2 chk("t5_grant_cpu", {31'b0, grant_dbg}, 0); chk("t5_addr_cpu", mem_addr, 32'h700);
    tick(); mem_ready = 0;
    #2 chk("t5_cpu_done", {31'b0, cpu_done}, 1);
    cpu_req = 0;
    tick(); tick();
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
